// File: rtl/reg_dst_tracker.sv
// -----------------------------------------------------------------------------
// reg_dst_tracker
//   Selects the register-file write destination at instruction capture and
//   queues it in an in-order FIFO of pending writebacks. The oldest pending
//   destination is presented to the register bank at writeback. Operand hazard
//   flags are derived from every pending, nonzero destination.
//
// Parameters
//   ADDR_W   register index width
//   DEPTH    pending-write entries (power of 2, >= 2)
//   SP_ADDR  index selected by reg_dst = 2'b10
//   RA_ADDR  index selected by reg_dst = 2'b11
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   reg_dst    in   00=rt_field, 01=rd_field, 10=SP_ADDR, 11=RA_ADDR
//   rt_field   in   IR[20:16]
//   rd_field   in   IR[15:11]
//   alloc      in   push the selected destination this cycle
//   retire     in   pop the head (writeback performed this cycle)
//   rs_query   in   operand index to check
//   rt_query   in   operand index to check
//   wb_addr    out  head destination (0 when empty)
//   wb_valid   out  FIFO not empty
//   full       out  count == DEPTH
//   count      out  number of pending entries
//   rs_hazard  out  rs_query matches a pending nonzero entry
//   rt_hazard  out  rt_query matches a pending nonzero entry
//   overflow   out  sticky: alloc while full without retire
//   underflow  out  sticky: retire while empty
// -----------------------------------------------------------------------------
module reg_dst_tracker #(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 4,
  parameter int SP_ADDR = 29,
  parameter int RA_ADDR = 31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 reg_dst,
  input  logic [ADDR_W-1:0]          rt_field,
  input  logic [ADDR_W-1:0]          rd_field,
  input  logic                       alloc,
  input  logic                       retire,
  input  logic [ADDR_W-1:0]          rs_query,
  input  logic [ADDR_W-1:0]          rt_query,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic                       wb_valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       rs_hazard,
  output logic                       rt_hazard,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_SP = 2'b10,
    DST_RA = 2'b11
  } dst_sel_e;

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic              overflow_q, underflow_q;

  logic [ADDR_W-1:0] dst_addr;
  logic              is_full, is_empty;
  logic              alloc_acc, retire_acc;

  // Destination mux.
  always_comb begin
    // NOTE: default assigned first so no path leaves dst_addr unassigned (no latch).
    dst_addr = rt_field;
    unique case (dst_sel_e'(reg_dst))
      DST_RT: dst_addr = rt_field;
      DST_RD: dst_addr = rd_field;
      DST_SP: dst_addr = ADDR_W'(SP_ADDR);
      DST_RA: dst_addr = ADDR_W'(RA_ADDR);
    endcase
  end

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // an empty FIFO never accepts a pop (no same-cycle bypass).
  assign alloc_acc  = alloc && (!is_full || retire);
  assign retire_acc = retire && !is_empty;

  // Control state: pointers, count, per-entry valid bits and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (retire_acc) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      // When full, head == tail: the push must win over the pop's valid clear,
      // so it is written after it.
      if (alloc_acc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(alloc_acc) - CNT_W'(retire_acc);
      if (alloc && !alloc_acc) overflow_q  <= 1'b1;
      if (retire && is_empty)  underflow_q <= 1'b1;
    end
  end

  // NOTE: the address storage is deliberately not reset; every read of it is
  // qualified by a valid bit or count, which are reset.
  always_ff @(posedge clk) begin
    if (alloc_acc) addr_q[tail_q] <= dst_addr;
  end

  // Hazards see registered, valid, nonzero entries only; $zero never hazards.
  always_comb begin
    rs_hazard = 1'b0;
    rt_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] != '0)) begin
        if (addr_q[i] == rs_query) rs_hazard = 1'b1;
        if (addr_q[i] == rt_query) rt_hazard = 1'b1;
      end
    end
  end

  assign wb_valid  = !is_empty;
  assign wb_addr   = wb_valid ? addr_q[head_q] : '0;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_reg_dst_tracker.sv
// -----------------------------------------------------------------------------
// tb_reg_dst_tracker
//   Self-checking bench for reg_dst_tracker. A queue holds the expected
//   destinations in allocation order; entries are pushed when an accepted
//   alloc is driven and popped/compared against wb_addr on each accepted
//   retire. Each scenario task also checks the status outputs inline.
// -----------------------------------------------------------------------------
module tb_reg_dst_tracker;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        reg_dst;
  logic [ADDR_W-1:0] rt_field, rd_field;
  logic              alloc, retire;
  logic [ADDR_W-1:0] rs_query, rt_query;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_valid, full;
  logic [CNT_W-1:0]  count;
  logic              rs_hazard, rt_hazard, overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic              exp_ovf = 1'b0;
  logic              exp_unf = 1'b0;

  reg_dst_tracker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SP_ADDR(29), .RA_ADDR(31)) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_dst   (reg_dst),
    .rt_field  (rt_field),
    .rd_field  (rd_field),
    .alloc     (alloc),
    .retire    (retire),
    .rs_query  (rs_query),
    .rt_query  (rt_query),
    .wb_addr   (wb_addr),
    .wb_valid  (wb_valid),
    .full      (full),
    .count     (count),
    .rs_hazard (rs_hazard),
    .rt_hazard (rt_hazard),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [ADDR_W-1:0] model_dst(input logic [1:0] sel,
                                                  input logic [ADDR_W-1:0] rt,
                                                  input logic [ADDR_W-1:0] rd);
    case (sel)
      2'b00:   return rt;
      2'b01:   return rd;
      2'b10:   return 5'd29;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] exp_head();
    return (exp_q.size() > 0) ? exp_q[0] : '0;
  endfunction

  // One clock of stimulus; called at least 1ns after a rising edge, returns
  // 1ns after the next one. Retired heads are compared against the scoreboard.
  task automatic cycle(input logic a, input logic r, input logic [1:0] sel,
                       input logic [ADDR_W-1:0] rt, input logic [ADDR_W-1:0] rd);
    logic              a_acc, r_acc;
    logic [ADDR_W-1:0] head;
    alloc    = a;
    retire   = r;
    reg_dst  = sel;
    rt_field = rt;
    rd_field = rd;
    a_acc = a && ((exp_q.size() < DEPTH) || r);
    r_acc = r && (exp_q.size() > 0);
    #2;
    if (r_acc) begin
      head = exp_q.pop_front();
      n_vec++;
      if (wb_addr !== head) begin
        n_err++;
        $display("FAIL retire_order: wb_addr=%0d expected=%0d", wb_addr, head);
      end
    end
    if (a && !a_acc) exp_ovf = 1'b1;
    if (r && !r_acc) exp_unf = 1'b1;
    if (a_acc) exp_q.push_back(model_dst(sel, rt, rd));
    @(posedge clk);
    #1;
    alloc  = 1'b0;
    retire = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reg_dst = '0; rt_field = '0; rd_field = '0;
    alloc = 1'b0; retire = 1'b0; rs_query = '0; rt_query = '0;
    #3;
    n_vec++;
    if ({wb_addr, wb_valid, full, count, rs_hazard, rt_hazard, overflow, underflow} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: wb_addr=%0d wb_valid=%b full=%b count=%0d rs_h=%b rt_h=%b ovf=%b unf=%b expected all 0",
               wb_addr, wb_valid, full, count, rs_hazard, rt_hazard, overflow, underflow);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    rs_query = 5'd9; rt_query = 5'd0;
    reg_dst = 2'b01; rd_field = 5'd9; rt_field = 5'd3; alloc = 1'b1;
    #2;
    n_vec++;
    if (rs_hazard !== 1'b0) begin
      n_err++; $display("FAIL hazard_same_cycle: rs_hazard=%b expected=0", rs_hazard);
    end
    @(posedge clk);
    #1;
    alloc = 1'b0;
    exp_q.push_back(5'd9);
    n_vec++;
    if ({wb_valid, wb_addr, count} !== {1'b1, 5'd9, CNT_W'(1)}) begin
      n_err++;
      $display("FAIL single_alloc: wb_valid=%b wb_addr=%0d count=%0d expected 1/9/1", wb_valid, wb_addr, count);
    end
    n_vec++;
    if (rs_hazard !== 1'b1) begin
      n_err++; $display("FAIL rs_hazard_hit: rs_hazard=%b expected=1", rs_hazard);
    end
    rt_query = 5'd9; rs_query = 5'd8;
    #1;
    n_vec++;
    if ({rs_hazard, rt_hazard} !== 2'b01) begin
      n_err++; $display("FAIL query_select: rs_h=%b rt_h=%b expected 0/1", rs_hazard, rt_hazard);
    end
    rs_query = 5'd9;
    cycle(1'b0, 1'b1, 2'b00, 5'd0, 5'd0);
    n_vec++;
    if ({wb_valid, rs_hazard, rt_hazard, wb_addr} !== '0) begin
      n_err++;
      $display("FAIL single_retire: wb_valid=%b rs_h=%b rt_h=%b wb_addr=%0d expected all 0",
               wb_valid, rs_hazard, rt_hazard, wb_addr);
    end
  endtask

  task automatic test_fill_order();
    cycle(1'b1, 1'b0, 2'b00, 5'd4, 5'd0);
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd7);
    cycle(1'b1, 1'b0, 2'b10, 5'd0, 5'd0);
    cycle(1'b1, 1'b0, 2'b11, 5'd0, 5'd0);
    n_vec++;
    if ({full, count} !== {1'b1, CNT_W'(4)}) begin
      n_err++; $display("FAIL fill_full: full=%b count=%0d expected 1/4", full, count);
    end
    rs_query = 5'd29; rt_query = 5'd31;
    #1;
    n_vec++;
    if ({rs_hazard, rt_hazard} !== 2'b11) begin
      n_err++; $display("FAIL sp_ra_hazard: rs_h=%b rt_h=%b expected 1/1", rs_hazard, rt_hazard);
    end
    repeat (4) cycle(1'b0, 1'b1, 2'b00, 5'd0, 5'd0);
    n_vec++;
    if ({wb_valid, full, wb_addr, count} !== '0) begin
      n_err++;
      $display("FAIL drain_empty: wb_valid=%b full=%b wb_addr=%0d count=%0d expected all 0",
               wb_valid, full, wb_addr, count);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd1);
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd2);
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd3);
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd5);
    cycle(1'b1, 1'b1, 2'b01, 5'd0, 5'd12);
    n_vec++;
    if ({count, full, overflow, wb_addr} !== {CNT_W'(4), 1'b1, 1'b0, 5'd2}) begin
      n_err++;
      $display("FAIL full_alloc_retire: count=%0d full=%b ovf=%b wb_addr=%0d expected 4/1/0/2",
               count, full, overflow, wb_addr);
    end
    repeat (4) cycle(1'b0, 1'b1, 2'b00, 5'd0, 5'd0);
    n_vec++;
    if (exp_q.size() != 0 || wb_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_drain: wb_valid=%b expected=0", wb_valid);
    end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 2'b01, 5'd0, ADDR_W'(16 + i));
    rs_query = 5'd20;
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd20);
    n_vec++;
    if ({overflow, count, wb_addr, rs_hazard} !== {1'b1, CNT_W'(4), 5'd16, 1'b0}) begin
      n_err++;
      $display("FAIL overflow: ovf=%b count=%0d wb_addr=%0d rs_h=%b expected 1/4/16/0",
               overflow, count, wb_addr, rs_hazard);
    end
    repeat (4) cycle(1'b0, 1'b1, 2'b00, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 2'b00, 5'd0, 5'd0);
    n_vec++;
    if ({underflow, count} !== {exp_unf, CNT_W'(0)}) begin
      n_err++; $display("FAIL underflow: unf=%b count=%0d expected 1/0", underflow, count);
    end
    cycle(1'b1, 1'b1, 2'b01, 5'd0, 5'd21);
    n_vec++;
    if ({count, wb_valid, wb_addr} !== {CNT_W'(exp_q.size()), 1'b1, exp_head()}) begin
      n_err++;
      $display("FAIL empty_alloc_retire: count=%0d wb_valid=%b wb_addr=%0d expected 1/1/21",
               count, wb_valid, wb_addr);
    end
    cycle(1'b0, 1'b1, 2'b00, 5'd0, 5'd0);
    n_vec++;
    if ({overflow, underflow} !== {exp_ovf, exp_unf}) begin
      n_err++; $display("FAIL sticky_flags: ovf=%b unf=%b expected %b/%b", overflow, underflow, exp_ovf, exp_unf);
    end
  endtask

  task automatic test_zero();
    do_reset();
    n_vec++;
    if ({overflow, underflow} !== 2'b00) begin
      n_err++; $display("FAIL flags_cleared: ovf=%b unf=%b expected 0/0", overflow, underflow);
    end
    rs_query = 5'd0; rt_query = 5'd0;
    cycle(1'b1, 1'b0, 2'b00, 5'd0, 5'd6);
    n_vec++;
    if ({rs_hazard, rt_hazard, wb_valid, wb_addr, count} !== {1'b0, 1'b0, 1'b1, 5'd0, CNT_W'(1)}) begin
      n_err++;
      $display("FAIL zero_dst: rs_h=%b rt_h=%b wb_valid=%b wb_addr=%0d count=%0d expected 0/0/1/0/1",
               rs_hazard, rt_hazard, wb_valid, wb_addr, count);
    end
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd6);
    cycle(1'b0, 1'b1, 2'b00, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 2'b00, 5'd0, 5'd0);
  endtask

  task automatic test_wrap_reset();
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 2'b01, 5'd0, ADDR_W'(2 + i));
    n_vec++;
    if ({count, wb_addr} !== {CNT_W'(1), exp_head()}) begin
      n_err++; $display("FAIL wrap_state: count=%0d wb_addr=%0d expected 1/%0d", count, wb_addr, exp_head());
    end
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd10);
    cycle(1'b1, 1'b0, 2'b11, 5'd0, 5'd0);
    cycle(1'b1, 1'b0, 2'b00, 5'd0, 5'd0);
    rs_query = 5'd10; rt_query = 5'd31;
    #1;
    n_vec++;
    if ({rs_hazard, rt_hazard, full, wb_addr} !== {1'b1, 1'b1, 1'b1, 5'd7}) begin
      n_err++;
      $display("FAIL wrap_full: rs_h=%b rt_h=%b full=%b wb_addr=%0d expected 1/1/1/7",
               rs_hazard, rt_hazard, full, wb_addr);
    end
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd13);
    #2;
    reset = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #1;
    n_vec++;
    if ({wb_addr, wb_valid, full, count, rs_hazard, rt_hazard, overflow, underflow} !== '0) begin
      n_err++;
      $display("FAIL async_reset: wb_addr=%0d wb_valid=%b full=%b count=%0d rs_h=%b rt_h=%b ovf=%b unf=%b expected all 0",
               wb_addr, wb_valid, full, count, rs_hazard, rt_hazard, overflow, underflow);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 1'b0, 2'b01, 5'd0, 5'd14);
    n_vec++;
    if ({count, wb_addr} !== {CNT_W'(1), 5'd14}) begin
      n_err++; $display("FAIL post_reset_alloc: count=%0d wb_addr=%0d expected 1/14", count, wb_addr);
    end
    cycle(1'b0, 1'b1, 2'b00, 5'd0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_back_to_back();
    test_overflow_underflow();
    test_zero();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
